// File: rtl/match_collector.sv
// Collects per-lane match windows from the PE array and serialises them into
// byte positions, one per handshake, in ascending lane order within each word.
module match_collector (
  input  logic        clk,
  input  logic        reset,
  input  logic        win_valid,
  input  logic [7:0]  win_in,
  input  logic        win_last,
  output logic        win_ready,
  output logic        match_valid,
  output logic [15:0] match_pos,
  output logic        match_last,
  input  logic        out_ready,
  output logic        done,
  output logic [15:0] match_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_pending;
  logic        r_last_flag;
  logic [12:0] r_word_idx;
  logic [15:0] r_match_count;
  logic        r_new_stream;

  logic        w_accept;
  logic        w_take;
  logic [2:0]  w_lane;
  logic [7:0]  w_pending_rest;
  logic        w_one_left;

  // Lowest-set-bit encoder; scanning from the top lets the lowest lane win.
  always_comb begin
    w_lane = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_lane = 3'(k);
      end
    end
  end

  assign w_pending_rest = r_pending & (r_pending - 8'd1);
  assign w_one_left     = (r_pending != 8'd0) && (w_pending_rest == 8'd0);

  assign win_ready   = (r_state == IDLE);
  assign match_valid = (r_state == DRAIN);
  assign done        = (r_state == DONE);
  assign match_pos   = match_valid ? {r_word_idx, w_lane} : 16'h0000;
  assign match_last  = match_valid && r_last_flag && w_one_left;
  assign match_count = r_match_count;

  assign w_accept = win_valid && win_ready;
  assign w_take   = match_valid && out_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (win_in != 8'd0) begin
            w_next_state = DRAIN;
          end else if (win_last) begin
            w_next_state = DONE;
          end
        end
      end
      DRAIN: begin
        if (w_take && w_one_left) begin
          w_next_state = r_last_flag ? DONE : IDLE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // match_count survives the done pulse and is only cleared once the next stream starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pending     <= 8'd0;
      r_last_flag   <= 1'b0;
      r_word_idx    <= 13'd0;
      r_match_count <= 16'd0;
      r_new_stream  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (r_new_stream) begin
              r_match_count <= 16'd0;
              r_new_stream  <= 1'b0;
            end
            if (win_in != 8'd0) begin
              r_pending   <= win_in;
              r_last_flag <= win_last;
            end else if (!win_last) begin
              r_word_idx <= r_word_idx + 13'd1;
            end
          end
        end
        DRAIN: begin
          if (w_take) begin
            r_pending <= w_pending_rest;
            if (r_match_count != 16'hFFFF) begin
              r_match_count <= r_match_count + 16'd1;
            end
            if (w_one_left) begin
              r_word_idx <= r_word_idx + 13'd1;
            end
          end
        end
        DONE: begin
          r_word_idx   <= 13'd0;
          r_new_stream <= 1'b1;
        end
        default: begin
          r_pending <= 8'd0;
        end
      endcase
    end
  end

endmodule
